// File: rtl/treepe_seq.sv
// treepe_seq: sequencer in front of the 8-lane fp32 tree/accumulator PE.
// Takes a reduction command (start, len), clears the PE accumulator, streams
// len 256-bit beats onto the PE lanes, waits out the PE pipeline, then
// captures pe_out and holds it until the consumer takes it.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start, len         command strobe and beat count (sampled in IDLE only)
//   busy               high whenever not IDLE
//   in_valid/in_ready  input beat handshake, in_data = 8 fp32 lanes
//   acc_clr            PE accumulator reset
//   pe_a               registered lane data to the PE (zero when no beat)
//   pe_out             PE accumulator output
//   res_valid/ready    result handshake, res_data = captured fp32 result
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start
// CLR    | one cycle with acc_clr high
// STREAM | accepting beats until remaining reaches zero
// DRAIN  | zero-filling the PE while its pipeline empties
// HOLD   | result valid, waiting for res_ready

module treepe_seq #(
   parameter int PIPE_LAT = 8,
   parameter int LEN_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [255:0]     in_data,
   output logic             acc_clr,
   output logic [255:0]     pe_a,
   input  logic [31:0]      pe_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_data
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLR    = 3'd1,
      STREAM = 3'd2,
      DRAIN  = 3'd3,
      HOLD   = 3'd4
   } state_t;

   localparam logic [7:0] DRAIN_LOAD = 8'(PIPE_LAT);

   state_t           state_q, state_d;
   logic [LEN_W-1:0] remaining;
   logic [7:0]       drain_cnt;
   logic             xfer;
   logic             last_beat;

   assign xfer      = in_valid & in_ready;
   assign last_beat = xfer && (remaining == LEN_W'(1));

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      busy     = (state_q != IDLE);
      in_ready = (state_q == STREAM);
      case (state_q)
         IDLE:    if (start) state_d = CLR;
         CLR:     state_d = (remaining != '0) ? STREAM : DRAIN;
         STREAM:  if (last_beat) state_d = DRAIN;
         DRAIN:   if (drain_cnt == 8'd0) state_d = HOLD;
         HOLD:    if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         remaining <= '0;
         drain_cnt <= '0;
         pe_a      <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         acc_clr   <= 1'b1;
      end else begin
         acc_clr <= (state_q == IDLE) && start;
         // Idle lanes carry +0.0 so they never disturb the running sum.
         pe_a    <= xfer ? in_data : '0;

         if ((state_q == IDLE) && start) remaining <= len;
         else if (xfer)                  remaining <= remaining - LEN_W'(1);

         if (((state_q == CLR) && (remaining == '0)) || last_beat)
            drain_cnt <= DRAIN_LOAD;
         else if ((state_q == DRAIN) && (drain_cnt != 8'd0))
            drain_cnt <= drain_cnt - 8'd1;

         if ((state_q == DRAIN) && (drain_cnt == 8'd0)) begin
            res_data  <= pe_out;
            res_valid <= 1'b1;
         end else if ((state_q == HOLD) && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_treepe_seq.sv
module tb_treepe_seq;
   localparam int PIPE_LAT = 8;
   localparam int LEN_W    = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [LEN_W-1:0] len;
   logic             busy;
   logic             in_valid;
   logic             in_ready;
   logic [255:0]     in_data;
   logic             acc_clr;
   logic [255:0]     pe_a;
   logic [31:0]      pe_out;
   logic             res_valid;
   logic             res_ready;
   logic [31:0]      res_data;

   treepe_seq #(.PIPE_LAT(PIPE_LAT), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .acc_clr(acc_clr), .pe_a(pe_a), .pe_out(pe_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int clr_cnt  = 0;
   int rdy_cnt  = 0;
   int basic_lat = 0;
   logic [31:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (acc_clr)  clr_cnt <= clr_cnt + 1;
      if (in_ready) rdy_cnt <= rdy_cnt + 1;
   end

   // PE stand-in: lane values are small exact integers, summed as integers.
   function automatic int fp_to_int(input logic [31:0] b);
      int e;
      logic [31:0] m;
      if (b[30:23] == 8'd0) return 0;
      e = int'(b[30:23]) - 127;
      m = {8'd0, 1'b1, b[22:0]};
      if (e <= 23) return int'(m >> (23 - e));
      return int'(m << (e - 23));
   endfunction

   function automatic logic [31:0] int_to_fp(input int v);
      logic [31:0] u, mant;
      logic [7:0]  ex;
      int p;
      if (v <= 0) return 32'h0;
      u = v;
      p = 0;
      for (int i = 0; i < 32; i++) if (u[i]) p = i;
      mant = (p >= 23) ? (u >> (p - 23)) : (u << (23 - p));
      ex = 8'(p + 127);
      return {1'b0, ex, mant[22:0]};
   endfunction

   function automatic int lane_sum(input logic [255:0] v);
      int s = 0;
      for (int i = 0; i < 8; i++) s += fp_to_int(v[32*i +: 32]);
      return s;
   endfunction

   int pipe_m [PIPE_LAT-1];
   int acc_m = 0;
   always @(posedge clk) begin
      if (acc_clr) begin
         acc_m <= 0;
         for (int i = 0; i < PIPE_LAT-1; i++) pipe_m[i] <= 0;
      end else begin
         acc_m     <= acc_m + pipe_m[PIPE_LAT-2];
         pipe_m[0] <= lane_sum(pe_a);
         for (int i = 1; i < PIPE_LAT-1; i++) pipe_m[i] <= pipe_m[i-1];
      end
   end
   assign pe_out = int_to_fp(acc_m);

   function automatic logic [31:0] pop_exp();
      if (exp_q.size() == 0) return 32'hxxxxxxxx;
      return exp_q.pop_front();
   endfunction

   task automatic issue_start(input int n, output int s_edge);
      start  = 1'b1;
      len    = LEN_W'(n);
      s_edge = cyc + 1;
      @(negedge clk);
      start  = 1'b0;
   endtask

   task automatic send_beat(input logic [31:0] lane, output int a_edge, output bit ok);
      ok = 1'b0;
      a_edge = 0;
      in_valid = 1'b1;
      in_data  = {8{lane}};
      for (int i = 0; i < 50; i++) begin
         if (in_ready) begin
            a_edge = cyc + 1;
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
   endtask

   task automatic wait_result(output int cap, output bit ok);
      ok = 1'b0;
      cap = 0;
      for (int i = 0; i < 300; i++) begin
         if (res_valid) begin
            ok = 1'b1;
            cap = cyc;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (in_ready !== 1'b0)  begin failures++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
      checks++; if (pe_a !== '0)        begin failures++; $display("FAIL reset_pe_a got %h exp 0", pe_a); end
      checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
      checks++; if (res_data !== 32'h0) begin failures++; $display("FAIL reset_res_data got %h exp 0", res_data); end
      checks++; if (acc_clr !== 1'b1)   begin failures++; $display("FAIL reset_acc_clr got %b exp 1", acc_clr); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (acc_clr !== 1'b0)   begin failures++; $display("FAIL reset_release_acc_clr got %b exp 0", acc_clr); end
   endtask

   task automatic test_basic_sum();
      int s, a0, a1, cap, c0;
      bit ok0, ok1, okr;
      logic [31:0] e;
      c0 = clr_cnt;
      exp_q.push_back(32'h41C00000);
      issue_start(2, s);
      send_beat(32'h3F800000, a0, ok0);
      send_beat(32'h40000000, a1, ok1);
      checks++; if (!(ok0 && ok1)) begin failures++; $display("FAIL basic_accept got %b%b exp 11", ok0, ok1); end
      wait_result(cap, okr);
      checks++; if (!okr) begin failures++; $display("FAIL basic_timeout got none exp res_valid"); end
      checks++; if (cap - a1 !== PIPE_LAT + 1) begin failures++; $display("FAIL basic_latency got %0d exp %0d", cap - a1, PIPE_LAT + 1); end
      basic_lat = cap - s;
      e = pop_exp();
      checks++; if (res_data !== e) begin failures++; $display("FAIL basic_data got %h exp %h", res_data, e); end
      @(negedge clk);
      checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin failures++; $display("FAIL basic_release got busy=%b valid=%b exp 0 0", busy, res_valid); end
      checks++; if (clr_cnt - c0 !== 1) begin failures++; $display("FAIL basic_clr_pulses got %0d exp 1", clr_cnt - c0); end
   endtask

   task automatic test_input_gaps();
      int s, a0, a1, cap, gap_bad;
      bit ok0, ok1, okr;
      logic [31:0] e;
      gap_bad = 0;
      exp_q.push_back(32'h41C00000);
      issue_start(2, s);
      send_beat(32'h3F800000, a0, ok0);
      repeat (3) begin
         @(negedge clk);
         if (pe_a !== '0) gap_bad++;
      end
      send_beat(32'h40000000, a1, ok1);
      checks++; if (gap_bad !== 0) begin failures++; $display("FAIL gap_pe_a_zero got %0d nonzero cycles exp 0", gap_bad); end
      checks++; if (a1 - a0 !== 4) begin failures++; $display("FAIL gap_beat_spacing got %0d exp 4", a1 - a0); end
      wait_result(cap, okr);
      checks++; if (!okr || cap - s !== basic_lat + 3) begin failures++; $display("FAIL gap_latency got %0d exp %0d", cap - s, basic_lat + 3); end
      e = pop_exp();
      checks++; if (res_data !== e) begin failures++; $display("FAIL gap_data got %h exp %h", res_data, e); end
      @(negedge clk);
   endtask

   task automatic test_len_zero();
      int s, cap, r0, c0;
      bit okr;
      logic [31:0] e;
      r0 = rdy_cnt;
      c0 = clr_cnt;
      exp_q.push_back(32'h00000000);
      issue_start(0, s);
      wait_result(cap, okr);
      checks++; if (!okr || cap !== s + 1 + PIPE_LAT + 1) begin failures++; $display("FAIL len0_latency got %0d exp %0d", cap, s + PIPE_LAT + 2); end
      checks++; if (rdy_cnt !== r0) begin failures++; $display("FAIL len0_in_ready got %0d cycles exp 0", rdy_cnt - r0); end
      checks++; if (clr_cnt - c0 !== 1) begin failures++; $display("FAIL len0_clr_pulses got %0d exp 1", clr_cnt - c0); end
      e = pop_exp();
      checks++; if (res_data !== e) begin failures++; $display("FAIL len0_data got %h exp %h", res_data, e); end
      @(negedge clk);
   endtask

   task automatic test_result_backpressure();
      int s, a0, cap, bad;
      bit ok0, okr;
      logic [31:0] held, e;
      bad = 0;
      res_ready = 1'b0;
      exp_q.push_back(32'h41000000);
      issue_start(1, s);
      send_beat(32'h3F800000, a0, ok0);
      wait_result(cap, okr);
      checks++; if (!(ok0 && okr)) begin failures++; $display("FAIL bp_progress got %b%b exp 11", ok0, okr); end
      held = res_data;
      for (int i = 0; i < 10; i++) begin
         start = (i == 4);
         len   = LEN_W'(1);
         @(negedge clk);
         if (res_data !== held || busy !== 1'b1 || res_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      end
      start = 1'b0;
      checks++; if (bad !== 0) begin failures++; $display("FAIL bp_hold got %0d bad cycles exp 0", bad); end
      e = pop_exp();
      checks++; if (res_data !== e) begin failures++; $display("FAIL bp_data got %h exp %h", res_data, e); end
      res_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b0 || res_valid !== 1'b0) begin failures++; $display("FAIL bp_accept_start_ignored got busy=%b valid=%b exp 0 0", busy, res_valid); end
      exp_q.push_back(32'h41800000);
      issue_start(1, s);
      send_beat(32'h40000000, a0, ok0);
      wait_result(cap, okr);
      e = pop_exp();
      checks++; if (!(ok0 && okr) || res_data !== e) begin failures++; $display("FAIL bp_new_cmd got %h exp %h", res_data, e); end
      @(negedge clk);
   endtask

   task automatic test_reset_mid_stream();
      int s, a0, a1, cap;
      bit ok0, ok1, okr;
      logic [31:0] e;
      issue_start(4, s);
      send_beat(32'h3F800000, a0, ok0);
      send_beat(32'h3F800000, a1, ok1);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (res_valid !== 1'b0 || pe_a !== '0) begin failures++; $display("FAIL rstmid_outputs got valid=%b pe_a=%h exp 0 0", res_valid, pe_a); end
      checks++; if (acc_clr !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_state got clr=%b busy=%b exp 1 0", acc_clr, busy); end
      rst = 1'b0;
      @(negedge clk);
      exp_q.push_back(32'h41000000);
      issue_start(1, s);
      send_beat(32'h3F800000, a0, ok0);
      wait_result(cap, okr);
      e = pop_exp();
      checks++; if (!(ok0 && okr) || res_data !== e) begin failures++; $display("FAIL rstmid_next_cmd got %h exp %h", res_data, e); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int s, a0, cap, c0;
      bit ok0, okr;
      logic [31:0] e;
      c0 = clr_cnt;
      exp_q.push_back(32'h41000000);
      exp_q.push_back(32'h41C00000);
      issue_start(1, s);
      send_beat(32'h3F800000, a0, ok0);
      wait_result(cap, okr);
      e = pop_exp();
      checks++; if (!(ok0 && okr) || res_data !== e) begin failures++; $display("FAIL b2b_first got %h exp %h", res_data, e); end
      @(negedge clk);
      issue_start(1, s);
      send_beat(32'h40400000, a0, ok0);
      wait_result(cap, okr);
      e = pop_exp();
      checks++; if (!(ok0 && okr) || res_data !== e) begin failures++; $display("FAIL b2b_second got %h exp %h", res_data, e); end
      checks++; if (clr_cnt - c0 !== 2) begin failures++; $display("FAIL b2b_clr_pulses got %0d exp 2", clr_cnt - c0); end
      @(negedge clk);
      checks++; if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size()); end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; res_ready = 1'b1;
      @(negedge clk);
      test_reset();
      test_basic_sum();
      test_input_gaps();
      test_len_zero();
      test_result_backpressure();
      test_reset_mid_stream();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/treepe_seq.md
Name: treepe_seq

Overview:
- Sequencer that sits directly upstream of the 8-lane fp32 tree/accumulator PE and collects its result.
- Accepts a reduction command (start, len) and streams len 8-lane fp32 beats into the PE lanes over a valid/ready handshake.
- Issues the accumulator clear before the first beat, waits out the PE pipeline latency, then captures the PE output into a result register.
- Presents that result over a valid/ready handshake. The result is a dot-product/vector-sum of len×8 elements.

Parameters:
- PIPE_LAT, 8: clock edges from a beat on pe_a until its contribution is visible on pe_out (tree + accumulator latency); legal range 1..255.
- LEN_W, 16: width of the len field.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  command strobe; sampled only in IDLE
- len  in  LEN_W  number of 256-bit beats in the reduction; sampled with start
- busy  out  1  high in every state except IDLE
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat ready
- in_data  in  256  8 fp32 lanes; lane i = bits [32i+31:32i]
- acc_clr  out  1  drives the PE accumulator rst
- pe_a  out  256  registered lane data to the PE (A0 = bits [31:0] … A7 = bits [255:224])
- pe_out  in  32  PE accumulator output
- res_valid  out  1  result valid
- res_ready  in  1  result accepted
- res_data  out  32  captured fp32 result

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values (rst high at an edge): state=IDLE, busy=0, in_ready=0, pe_a=0, res_valid=0, res_data=0, acc_clr=1. acc_clr returns to 0 on the first edge with rst low. rst mid-operation aborts the command immediately; no partial result is emitted.
- All outputs are registered except in_ready and busy, which decode state.
- State machine: IDLE, CLR, STREAM, DRAIN, HOLD.
- IDLE:
  - in_ready=0.
  - start=1 at an edge: latch len into remaining, go to CLR.
  - start outside IDLE is ignored (no queuing).
- CLR:
  - Exactly one cycle; acc_clr=1 during it (registered, asserted on the edge entering CLR), in_ready=0.
  - Next state is STREAM if remaining≠0, else DRAIN.
- STREAM:
  - in_ready=1.
  - Each edge with in_valid&in_ready: pe_a←in_data, remaining decrements.
  - Each edge without a transfer: pe_a←0 (+0.0 on all lanes, neutral for the sum).
  - The edge accepting the last beat (remaining==1) moves to DRAIN and loads drain_cnt=PIPE_LAT.
- DRAIN:
  - in_ready=0; pe_a←0 each edge; drain_cnt decrements each edge.
  - When drain_cnt==0 at an edge: res_data←pe_out, res_valid←1, go to HOLD.
  - Net timing: res_valid rises exactly PIPE_LAT+1 edges after the edge that accepted the last beat.
  - len=0 case: the capture edge is PIPE_LAT+1 edges after the CLR exit edge; the result is the cleared accumulator value (0x00000000).
- HOLD:
  - res_valid=1; res_data stable.
  - res_valid&res_ready at an edge: res_valid←0, go to IDLE.
  - A start on the same edge as acceptance is ignored; the earliest new start is sampled in the next cycle.
- Back-pressure:
  - in_valid may drop mid-stream; gaps insert zeros and only extend the stream.
  - res_ready may stay low indefinitely; the block holds the result and accepts no new beats.
- Arithmetic: none inside this block. fp32 summation is done by the PE; the block only gates and zero-fills lanes.
- remaining is LEN_W bits; the maximum len is 2^LEN_W−1. No wrap occurs, because decrement happens only while remaining≥1.

Test Plan:
- Basic sum: len=2; beat0 all lanes 0x3F800000 (1.0), beat1 all lanes 0x40000000 (2.0), in_valid continuous, res_ready=1 → acc_clr pulses once, res_data=0x41C00000 (24.0), res_valid rises PIPE_LAT+1 edges after beat1 is accepted.
- Input gaps: same data as basic sum with in_valid low for 3 cycles between the beats → pe_a=0 during the gap, res_data=0x41C00000, res_valid delayed 3 cycles relative to the basic case.
- len=0: start with len=0 → no in_ready assertion, res_data=0x00000000 at PIPE_LAT+1 edges after CLR.
- Result back-pressure: hold res_ready=0 for 10 cycles, pulse start mid-HOLD → res_data stable, start ignored, busy=1; raise res_ready → IDLE, then a new start is accepted.
- Reset mid-stream: len=4, assert rst after 2 beats → next edge: res_valid=0, pe_a=0, acc_clr=1, IDLE. A following command with len=1 of all 0x3F800000 yields res_data=0x41000000 (8.0).
- Back-to-back commands: two len=1 commands (lanes 1.0, then lanes 0x40400000 (3.0)) → results 0x41000000 then 0x41C00000; the second result must not include the first (acc_clr verified between them).
